conv_pe_stream: RTL and testbench

Parametrised convolution processing element: multi-channel image and filter memories loaded over a write port, then one MAC per cycle. Each output pixel goes out on a valid/ready stream after zero-point subtraction, requantisation shift, optional ReLU and saturation. It is the configurable successor to the fixed single-size PE and drops into the same layer controller, which loads operands, pulses `start` and drains results.

---
 rtl/conv_pe_pkg.sv | 53 +++++
 rtl/pe_mac.sv | 50 +++++
 rtl/conv_pe_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_conv_pe_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_pkg
// Description : Shared state encoding, geometry helpers and requantisation
//               function for the convolution processing element.
// Revision    : 1.0
// ============================================================================
package conv_pe_pkg;

    localparam int SHIFT_W    = 5;
    localparam int STATE_W    = 2;
    localparam int SAT_CALC_W = 64;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_MAC  = 2'd1;
    localparam logic [STATE_W-1:0] ST_OUT  = 2'd2;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    // Arithmetic shift, optional ReLU, then clamp to a signed data_w range.
    function automatic logic signed [SAT_CALC_W-1:0] sat_relu(
        input logic signed [SAT_CALC_W-1:0] acc,
        input logic [SHIFT_W-1:0]           shift,
        input logic                         relu,
        input int                           data_w
    );
        logic signed [SAT_CALC_W-1:0] r;
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        r  = acc >>> shift;
        if (relu && r[SAT_CALC_W-1]) begin
            r = 64'sd0;
        end
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac
// Description : Clearable accumulator of (pix - z) * flt with a requantised,
//               saturated view of the value being written this cycle.
// Revision    : 1.0
// ============================================================================
module pe_mac
    import conv_pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DATA_W-1:0]  pix_i,
    input  logic [DATA_W-1:0]  z_i,
    input  logic [DATA_W-1:0]  flt_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_i,
    output logic [DATA_W-1:0]  res_o
);

    localparam int PROD_W = 2 * DATA_W + 1;

    logic signed [DATA_W:0]   w_diff;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    always_comb begin
        w_diff = $signed({1'b0, pix_i}) - $signed({1'b0, z_i});
        w_prod = PROD_W'(w_diff) * PROD_W'($signed(flt_i));
        acc_d  = (clr_i ? '0 : acc_q) + (en_i ? ACC_W'(w_prod) : '0);
        // Result reflects acc_d so the final tap is included on the same edge.
        res_o  = DATA_W'(sat_relu(SAT_CALC_W'(acc_d), shift_i, relu_i, DATA_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i || en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_pe_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv_pe_stream
// Description : Multi-channel convolution PE: loadable image/filter memories,
//               one MAC per cycle, valid/ready result stream.
// Revision    : 1.0
// ============================================================================
module conv_pe_stream
    import conv_pe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int IMG_SIZE = 16,
    parameter int K        = 4,
    parameter int NUM_CH   = 1,
    parameter int STRIDE   = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         ld_en,
    input  logic                                         ld_sel,
    input  logic [clog2_min1(NUM_CH)-1:0]                ld_ch,
    input  logic [clog2_min1(IMG_SIZE*IMG_SIZE)-1:0]     ld_adr,
    input  logic [DATA_W-1:0]                            ld_data,
    input  logic                                         start,
    input  logic [DATA_W-1:0]                            cfg_z,
    input  logic [SHIFT_W-1:0]                           cfg_shift,
    input  logic                                         cfg_relu,
    output logic                                         busy,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [DATA_W-1:0]                            out_data,
    output logic [clog2_min1(out_dim(IMG_SIZE, K, STRIDE) *
                             out_dim(IMG_SIZE, K, STRIDE))-1:0] out_idx,
    output logic                                         out_last,
    output logic                                         done
);

    localparam int OUT_DIM    = out_dim(IMG_SIZE, K, STRIDE);
    localparam int CH_W       = clog2_min1(NUM_CH);
    localparam int KW         = clog2_min1(K);
    localparam int OW         = clog2_min1(OUT_DIM);
    localparam int IDX_W      = clog2_min1(OUT_DIM * OUT_DIM);
    localparam int FA_W       = clog2_min1(K * K);
    localparam int IMEM_DEPTH = NUM_CH * IMG_SIZE * IMG_SIZE;
    localparam int FMEM_DEPTH = NUM_CH * K * K;
    localparam int IMEM_AW    = clog2_min1(IMEM_DEPTH);
    localparam int FMEM_AW    = clog2_min1(FMEM_DEPTH);

    localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);
    localparam logic [KW-1:0]   K_MAX  = KW'(K - 1);
    localparam logic [OW-1:0]   O_MAX  = OW'(OUT_DIM - 1);

    logic [DATA_W-1:0] img_mem [IMEM_DEPTH];
    logic [DATA_W-1:0] flt_mem [FMEM_DEPTH];

    state_t             state_q, state_d;
    logic [KW-1:0]      kx_q, kx_d, ky_q, ky_d;
    logic [CH_W-1:0]    c_q, c_d;
    logic [OW-1:0]      ox_q, ox_d, oy_q, oy_d;
    logic [DATA_W-1:0]  z_q, z_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               relu_q, relu_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;

    logic               w_ld_ok, w_ld_flt_ok;
    logic [FA_W-1:0]    w_ld_flt_lo;
    logic [IMEM_AW-1:0] w_ld_img_adr, w_rd_img_adr;
    logic [FMEM_AW-1:0] w_ld_flt_adr, w_rd_flt_adr;
    logic               w_last_tap, w_last_win;
    logic               w_mac_clr, w_mac_en;
    logic [DATA_W-1:0]  w_pix, w_flt, w_mac_res;

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

    always_comb begin
        w_ld_ok      = ld_en && !busy && (32'(ld_ch) < 32'(NUM_CH));
        w_ld_flt_lo  = ld_adr[FA_W-1:0];
        w_ld_flt_ok  = (32'(w_ld_flt_lo) < 32'(K * K));
        w_ld_img_adr = IMEM_AW'(32'(ld_ch) * 32'(IMG_SIZE * IMG_SIZE) + 32'(ld_adr));
        w_ld_flt_adr = FMEM_AW'(32'(ld_ch) * 32'(K * K) + 32'(w_ld_flt_lo));
        w_rd_img_adr = IMEM_AW'(32'(c_q) * 32'(IMG_SIZE * IMG_SIZE)
                     + (32'(oy_q) * 32'(STRIDE) + 32'(ky_q)) * 32'(IMG_SIZE)
                     + 32'(ox_q) * 32'(STRIDE) + 32'(kx_q));
        w_rd_flt_adr = FMEM_AW'(32'(c_q) * 32'(K * K) + 32'(ky_q) * 32'(K) + 32'(kx_q));
        w_pix        = img_mem[w_rd_img_adr];
        w_flt        = flt_mem[w_rd_flt_adr];
    end

    // Memories carry no reset so operands survive rst and successive layers.
    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            if (!ld_sel) begin
                img_mem[w_ld_img_adr] <= ld_data;
            end else if (w_ld_flt_ok) begin
                flt_mem[w_ld_flt_adr] <= ld_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        c_d        = c_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        z_d        = z_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        done_d     = 1'b0;
        w_mac_clr  = 1'b0;
        w_mac_en   = 1'b0;
        w_last_tap = (c_q == CH_MAX) && (ky_q == K_MAX) && (kx_q == K_MAX);
        w_last_win = (ox_q == O_MAX) && (oy_q == O_MAX);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_MAC;
                    w_mac_clr = 1'b1;
                    kx_d      = '0;
                    ky_d      = '0;
                    c_d       = '0;
                    ox_d      = '0;
                    oy_d      = '0;
                    z_d       = cfg_z;
                    shift_d   = cfg_shift;
                    relu_d    = cfg_relu;
                end
            end
            ST_MAC: begin
                w_mac_en = 1'b1;
                if (kx_q != K_MAX) begin
                    kx_d = kx_q + KW'(1);
                end else begin
                    kx_d = '0;
                    if (ky_q != K_MAX) begin
                        ky_d = ky_q + KW'(1);
                    end else begin
                        ky_d = '0;
                        c_d  = (c_q == CH_MAX) ? '0 : c_q + CH_W'(1);
                    end
                end
                if (w_last_tap) begin
                    state_d    = ST_OUT;
                    out_data_d = w_mac_res;
                    out_idx_d  = IDX_W'(32'(oy_q) * 32'(OUT_DIM) + 32'(ox_q));
                    out_last_d = w_last_win;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (w_last_win) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_MAC;
                        w_mac_clr = 1'b1;
                        if (ox_q != O_MAX) begin
                            ox_d = ox_q + OW'(1);
                        end else begin
                            ox_d = '0;
                            oy_d = oy_q + OW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            c_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            z_q        <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            c_q        <= c_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            z_q        <= z_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
            done_q     <= done_d;
        end
    end

    pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_pe_mac (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_mac_clr),
        .en_i    (w_mac_en),
        .pix_i   (w_pix),
        .z_i     (z_q),
        .flt_i   (w_flt),
        .shift_i (shift_q),
        .relu_i  (relu_q),
        .res_o   (w_mac_res)
    );

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_pe_stream
// Description : Two conv_pe_stream instances (4x4 image, K=2): dut0 single
//               channel stride 2, dut1 two channels stride 1, sharing loads.
// Revision    : 1.0
// ============================================================================
module tb_conv_pe_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en, ld_sel, start, cfg_relu;
    logic [0:0] ld_ch;
    logic [3:0] ld_adr;
    logic [7:0] ld_data, cfg_z;
    logic [4:0] cfg_shift;

    logic       busy0, out_valid0, rdy0, out_last0, done0;
    logic [7:0] out_data0;
    logic [1:0] out_idx0;
    logic       busy1, out_valid1, rdy1, out_last1, done1;
    logic [7:0] out_data1;
    logic [3:0] out_idx1;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  img_m [2][16];
    int  flt_m [2][4];
    int  z_m, sh_m;
    bit  relu_m;

    always #5 clk = ~clk;

    conv_pe_stream #(.DATA_W(8), .ACC_W(24), .IMG_SIZE(4), .K(2), .NUM_CH(1), .STRIDE(2)) u_dut0 (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_ch(ld_ch), .ld_adr(ld_adr),
        .ld_data(ld_data), .start(start), .cfg_z(cfg_z), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .busy(busy0), .out_valid(out_valid0), .out_ready(rdy0), .out_data(out_data0),
        .out_idx(out_idx0), .out_last(out_last0), .done(done0)
    );

    conv_pe_stream #(.DATA_W(8), .ACC_W(24), .IMG_SIZE(4), .K(2), .NUM_CH(2), .STRIDE(1)) u_dut1 (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_ch(ld_ch), .ld_adr(ld_adr),
        .ld_data(ld_data), .start(start), .cfg_z(cfg_z), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .busy(busy1), .out_valid(out_valid1), .out_ready(rdy1), .out_data(out_data1),
        .out_idx(out_idx1), .out_last(out_last1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Direct convolution of one output pixel from the model memories.
    function automatic int model(input int d, input int n);
        int     od, s, nch, oy, ox;
        longint acc;
        od  = (d == 0) ? 2 : 3;
        s   = (d == 0) ? 2 : 1;
        nch = (d == 0) ? 1 : 2;
        oy  = n / od;
        ox  = n % od;
        acc = 0;
        for (int c = 0; c < nch; c++)
            for (int ky = 0; ky < 2; ky++)
                for (int kx = 0; kx < 2; kx++)
                    acc += longint'(img_m[c][(oy * s + ky) * 4 + ox * s + kx] - z_m)
                         * longint'(flt_m[c][ky * 2 + kx]);
        acc = acc >>> sh_m;
        if (relu_m && acc < 0) acc = 0;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return int'(acc);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_valid0"}, out_valid0, 0);
        chk({tag, "_data0"}, out_data0, 0);
        chk({tag, "_idx0"}, out_idx0, 0);
        chk({tag, "_last0"}, out_last0, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_valid1"}, out_valid1, 0);
        chk({tag, "_data1"}, out_data1, 0);
        chk({tag, "_idx1"}, out_idx1, 0);
    endtask

    task automatic set_mem(input int i0, input int i1, input int f, input int z, input int sh, input bit r);
        for (int a = 0; a < 16; a++) begin
            img_m[0][a] = i0;
            img_m[1][a] = i1;
        end
        for (int t = 0; t < 4; t++) begin
            flt_m[0][t] = f;
            flt_m[1][t] = f;
        end
        z_m = z; sh_m = sh; relu_m = r;
    endtask

    task automatic load_all();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++) begin
                ld_en = 1'b1; ld_sel = 1'b0; ld_ch = 1'(c); ld_adr = 4'(a); ld_data = 8'(img_m[c][a]);
                @(posedge clk); #1;
            end
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 4; t++) begin
                ld_en = 1'b1; ld_sel = 1'b1; ld_ch = 1'(c); ld_adr = 4'(t); ld_data = 8'(flt_m[c][t]);
                @(posedge clk); #1;
            end
        ld_en = 1'b0;
    endtask

    // Entered 1 time unit after a rising edge; that cycle is cycle 0.
    task automatic run_layer(input int stall_at, input bit poke, input bit ld_with_start);
        int t, n0, n1, scnt;
        bit d0, d1;
        logic [7:0] e8;
        t = 1; n0 = 0; n1 = 0; scnt = 0; d0 = 1'b0; d1 = 1'b0;
        cfg_z = 8'(z_m); cfg_shift = 5'(sh_m); cfg_relu = relu_m;
        rdy0 = 1'b1; rdy1 = 1'b1;
        start = 1'b1;
        if (ld_with_start) begin
            img_m[0][5] = int'($urandom_range(0, 255));
            ld_en = 1'b1; ld_sel = 1'b0; ld_ch = 1'b0; ld_adr = 4'd5; ld_data = 8'(img_m[0][5]);
        end
        @(posedge clk); #1;
        start = 1'b0; ld_en = 1'b0;
        while (!(d0 && d1) && t < 400) begin
            rdy0 = 1'b1;
            if (out_valid0 && n0 == stall_at && scnt < 5) begin
                rdy0 = 1'b0;
                scnt++;
            end
            if (poke && t == 2) begin
                start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_ch = 1'b0; ld_adr = 4'd0;
                ld_data = 8'(img_m[0][0] ^ 255); cfg_z = 8'(z_m ^ 255);
            end else begin
                start = 1'b0; ld_en = 1'b0;
            end
            @(negedge clk);
            if (!d0) begin
                e8 = 8'(model(0, n0 > 3 ? 3 : n0));
                if (out_valid0 && rdy0) begin
                    chk("d0_data", out_data0, e8);
                    chk("d0_idx", out_idx0, n0);
                    chk("d0_last", out_last0, n0 == 3);
                    chk("d0_hs_cycle", t, (n0 + 1) * 5 + ((stall_at >= 0 && n0 >= stall_at) ? 5 : 0));
                    n0++;
                end else if (out_valid0) begin
                    chk("d0_hold_data", out_data0, e8);
                    chk("d0_hold_idx", out_idx0, n0);
                    chk("d0_hold_nodone", done0, 0);
                end
                if (done0) begin
                    chk("d0_count", n0, 4);
                    chk("d0_done_cycle", t, 21 + ((stall_at >= 0) ? 5 : 0));
                    chk("d0_busy_at_done", busy0, 0);
                    d0 = 1'b1;
                end
            end
            if (!d1) begin
                if (out_valid1) begin
                    e8 = 8'(model(1, n1 > 8 ? 8 : n1));
                    chk("d1_data", out_data1, e8);
                    chk("d1_idx", out_idx1, n1);
                    chk("d1_last", out_last1, n1 == 8);
                    chk("d1_hs_cycle", t, (n1 + 1) * 9);
                    n1++;
                end
                if (done1) begin
                    chk("d1_count", n1, 9);
                    chk("d1_done_cycle", t, 82);
                    chk("d1_busy_at_done", busy1, 0);
                    d1 = 1'b1;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0; ld_en = 1'b0;
        chk("layer_timeout", {30'd0, d0, d1}, 3);
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_ch = 1'b0; ld_adr = 4'd0; ld_data = 8'd0;
        start = 1'b0; cfg_z = 8'd0; cfg_shift = 5'd0; cfg_relu = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        set_mem(10, 10, 1, 2, 0, 0);
        load_all();
        run_layer(-1, 0, 0);

        set_mem(10, 10, -1, 2, 0, 0);
        load_all();
        run_layer(-1, 0, 0);
        relu_m = 1'b1;
        run_layer(-1, 0, 0);

        set_mem(255, 255, 127, 0, 0, 0);
        load_all();
        run_layer(-1, 0, 0);
        sh_m = 10;
        run_layer(-1, 0, 0);
        set_mem(255, 255, -128, 0, 0, 0);
        load_all();
        run_layer(-1, 0, 0);

        set_mem(1, 2, 1, 0, 0, 0);
        load_all();
        run_layer(1, 1, 0);

        cfg_z = 8'd0; cfg_shift = 5'd0; cfg_relu = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_reset("midmac_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_layer(-1, 0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 16; a++) img_m[c][a] = int'($urandom_range(0, 255));
                for (int t = 0; t < 4; t++) flt_m[c][t] = int'($urandom_range(0, 255)) - 128;
            end
            z_m    = int'($urandom_range(0, 255));
            sh_m   = int'($urandom_range(0, 10));
            relu_m = 1'($urandom_range(0, 1));
            load_all();
            run_layer(int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
